// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: debounces the three board keys and drives the
// enable / clear / load / display-hold controls of the BCD counter chain.
//
// Ports:
//   clk          system clock (CLOCK_50)
//   aclr         synchronous active-low reset, sampled on rising clk
//   tick         single-cycle 1 s strobe
//   key_start_n  raw start/stop key, active-low, asynchronous
//   key_lap_n    raw lap/reset key, active-low, asynchronous
//   key_load_n   raw preset-load key, active-low, asynchronous
//   top_roll     every counter stage at its terminal value
//   cnt_en       registered count enable pulse to the first stage
//   cnt_clr_n    registered active-low clear pulse to all stages
//   cnt_load     registered preset-load pulse
//   disp_hold    freeze display latch (lap view)
//   state        FSM state: IDLE=0, RUN=1, LAP=2, PAUSE=3

// Per-key synchroniser, debouncer and press-edge detector.
// press is a one-cycle strobe on the debounced 1->0 edge.
module sw_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic aclr,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!aclr) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      level_q <= 1'b1;
      cnt     <= '0;
    end else begin
      sync1   <= key_n;
      sync2   <= sync1;
      level_q <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Only the falling debounced edge is an event; release is silent.
  assign press = level_q & ~level;

endmodule

module stopwatch_ctrl #(
  parameter int DB_CYCLES   = 500000,
  parameter bit STOP_AT_MAX = 1'b1
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       tick,
  input  logic       key_start_n,
  input  logic       key_lap_n,
  input  logic       key_load_n,
  input  logic       top_roll,
  output logic       cnt_en,
  output logic       cnt_clr_n,
  output logic       cnt_load,
  output logic       disp_hold,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } st_t;

  st_t  st_q;
  st_t  st_d;

  logic p_start;
  logic p_lap;
  logic p_load;

  logic ev_start;
  logic ev_lap;
  logic ev_load;

  logic counting;
  logic at_max;

  logic en_d;
  logic clr_n_d;
  logic load_d;
  logic hold_d;

  sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk   (clk),
    .aclr  (aclr),
    .key_n (key_start_n),
    .press (p_start)
  );

  sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
    .clk   (clk),
    .aclr  (aclr),
    .key_n (key_lap_n),
    .press (p_lap)
  );

  sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (
    .clk   (clk),
    .aclr  (aclr),
    .key_n (key_load_n),
    .press (p_load)
  );

  // Priority start > lap > load; losers are dropped.
  assign ev_start = p_start;
  assign ev_lap   = p_lap & ~p_start;
  assign ev_load  = p_load & ~p_start & ~p_lap;

  // Tick qualification uses the pre-transition state.
  assign counting = (st_q == RUN) || (st_q == LAP);
  assign at_max   = STOP_AT_MAX & tick & counting & top_roll;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!aclr) begin
      st_q      <= IDLE;
      cnt_en    <= 1'b0;
      cnt_clr_n <= 1'b0;
      cnt_load  <= 1'b0;
      disp_hold <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_en    <= en_d;
      cnt_clr_n <= clr_n_d;
      cnt_load  <= load_d;
      disp_hold <= hold_d;
    end
  end

  // Next state. Auto-pause at max wins over a lap press in the same
  // cycle so the chain never counts past its terminal value.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: begin
        if (ev_start) st_d = RUN;
      end
      RUN: begin
        unique case (1'b1)
          ev_start: st_d = PAUSE;
          at_max:   st_d = PAUSE;
          ev_lap:   st_d = LAP;
          default:  st_d = RUN;
        endcase
      end
      LAP: begin
        unique case (1'b1)
          ev_start: st_d = PAUSE;
          at_max:   st_d = PAUSE;
          ev_lap:   st_d = RUN;
          default:  st_d = LAP;
        endcase
      end
      PAUSE: begin
        unique case (1'b1)
          ev_start: st_d = RUN;
          ev_lap:   st_d = IDLE;
          default:  st_d = PAUSE;
        endcase
      end
      default: st_d = IDLE;
    endcase
  end

  // Next output values, registered above.
  always_comb begin
    en_d    = tick & counting & ~at_max;
    clr_n_d = 1'b1;
    load_d  = 1'b0;
    hold_d  = disp_hold;
    unique case (st_q)
      IDLE: begin
        if (ev_lap)  clr_n_d = 1'b0;
        if (ev_load) load_d  = 1'b1;
        hold_d = 1'b0;
      end
      RUN: begin
        if (ev_lap && !at_max) hold_d = 1'b1;
      end
      LAP: begin
        if (ev_lap && !at_max) hold_d = 1'b0;
      end
      PAUSE: begin
        if (ev_start) hold_d = 1'b0;
        if (ev_lap) begin
          clr_n_d = 1'b0;
          hold_d  = 1'b0;
        end
        if (ev_load) load_d = 1'b1;
      end
      default: hold_d = 1'b0;
    endcase
  end

  assign state = st_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DB_CYCLES=4, STOP_AT_MAX=1.
// Inputs change 1 ns after posedge; outputs read there too.
module tb_stopwatch_ctrl;

  logic       clk;
  logic       aclr;
  logic       tick;
  logic       key_start_n;
  logic       key_lap_n;
  logic       key_load_n;
  logic       top_roll;
  logic       cnt_en;
  logic       cnt_clr_n;
  logic       cnt_load;
  logic       disp_hold;
  logic [1:0] state;

  int errors;
  int checks;
  int clr_seen;
  int load_seen;
  int en_seen;
  int clash;

  stopwatch_ctrl #(.DB_CYCLES(4), .STOP_AT_MAX(1'b1)) dut (
    .clk         (clk),
    .aclr        (aclr),
    .tick        (tick),
    .key_start_n (key_start_n),
    .key_lap_n   (key_lap_n),
    .key_load_n  (key_load_n),
    .top_roll    (top_roll),
    .cnt_en      (cnt_en),
    .cnt_clr_n   (cnt_clr_n),
    .cnt_load    (cnt_load),
    .disp_hold   (disp_hold),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tallies and the never-together rule.
  always @(negedge clk) begin
    if (!cnt_clr_n && aclr) clr_seen++;
    if (cnt_load) load_seen++;
    if (cnt_en) en_seen++;
    if ((32'(cnt_en) + 32'(cnt_load) + 32'(!cnt_clr_n)) > 1) clash++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // mask bit2=start, bit1=lap, bit0=load
  task automatic press(input logic [2:0] mask, input int n);
    key_start_n = ~mask[2];
    key_lap_n   = ~mask[1];
    key_load_n  = ~mask[0];
    steps(n);
    key_start_n = 1'b1;
    key_lap_n   = 1'b1;
    key_load_n  = 1'b1;
    steps(10);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    clr_seen    = 0;
    load_seen   = 0;
    en_seen     = 0;
    clash       = 0;
    aclr        = 1'b0;
    tick        = 1'b0;
    key_start_n = 1'b1;
    key_lap_n   = 1'b1;
    key_load_n  = 1'b1;
    top_roll    = 1'b0;

    steps(3);
    check("rst_state", 32'(state), 0);
    check("rst_clr_n", 32'(cnt_clr_n), 0);
    check("rst_en", 32'(cnt_en), 0);
    check("rst_load", 32'(cnt_load), 0);
    check("rst_hold", 32'(disp_hold), 0);
    aclr = 1'b1;
    step();
    check("rel_clr_n", 32'(cnt_clr_n), 1);

    // Idle with ticks: no enable.
    en_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick = (i % 10 == 0);
      step();
    end
    tick = 1'b0;
    check("idle_en", 32'(en_seen), 0);
    check("idle_state", 32'(state), 0);

    // Start: event 7 edges after key goes low.
    key_start_n = 1'b0;
    steps(6);
    check("start_early", 32'(state), 0);
    step();
    check("start_run", 32'(state), 1);
    step();
    key_start_n = 1'b1;
    steps(10);
    check("start_once", 32'(state), 1);

    pulse_tick();
    check("tick1_en", 32'(cnt_en), 1);
    step();
    check("tick1_low", 32'(cnt_en), 0);
    steps(8);
    pulse_tick();
    check("tick2_en", 32'(cnt_en), 1);
    step();
    check("tick2_low", 32'(cnt_en), 0);

    // Load ignored in RUN.
    load_seen = 0;
    press(3'b001, 8);
    check("run_load_ign", 32'(load_seen), 0);
    check("run_load_st", 32'(state), 1);

    // Lap view.
    press(3'b010, 8);
    check("lap_state", 32'(state), 2);
    check("lap_hold", 32'(disp_hold), 1);
    pulse_tick();
    check("lap_en", 32'(cnt_en), 1);
    press(3'b010, 8);
    check("unlap_state", 32'(state), 1);
    check("unlap_hold", 32'(disp_hold), 0);

    // Pause, clear, load.
    press(3'b100, 8);
    check("pause_state", 32'(state), 3);
    en_seen = 0;
    pulse_tick();
    step();
    check("pause_no_en", 32'(en_seen), 0);
    clr_seen = 0;
    press(3'b010, 8);
    check("clr_pulse", 32'(clr_seen), 1);
    check("clr_state", 32'(state), 0);
    load_seen = 0;
    clr_seen  = 0;
    press(3'b001, 8);
    check("load_pulse", 32'(load_seen), 1);
    check("load_noclr", 32'(clr_seen), 0);
    check("load_state", 32'(state), 0);

    // Glitch and simultaneous start+lap.
    press(3'b100, 3);
    check("glitch", 32'(state), 0);
    clr_seen = 0;
    press(3'b110, 8);
    check("simul_state", 32'(state), 1);
    check("simul_noclr", 32'(clr_seen), 0);

    // Auto-pause at max.
    top_roll = 1'b1;
    pulse_tick();
    top_roll = 1'b0;
    check("max_en", 32'(cnt_en), 0);
    check("max_state", 32'(state), 3);

    // Reset in LAP.
    press(3'b100, 8);
    check("resume_run", 32'(state), 1);
    press(3'b010, 8);
    check("lap2_state", 32'(state), 2);
    aclr = 1'b0;
    step();
    check("rstlap_state", 32'(state), 0);
    check("rstlap_hold", 32'(disp_hold), 0);
    check("rstlap_clr_n", 32'(cnt_clr_n), 0);
    aclr = 1'b1;
    step();
    check("rstlap_rel", 32'(cnt_clr_n), 1);

    check("never_together", 32'(clash), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
